wb_rr_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing one Wishbone master port on conbus (slot m2).

---
 rtl/wb_rr_arbiter_pkg.sv | 14 +
 rtl/wb_arb_watchdog.sv | 36 +++
 rtl/wb_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
//   arb_state_t      - grant FSM encoding (IDLE / GNT0 / GNT1)
//   TIMEOUT_DEFAULT  - default watchdog limit in cycles (0 disables it)
package wb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter's shared slave port.
// Counts cycles in which the granted master strobes without an ack and
// pulses timeout for one cycle when the count has reached TIMEOUT.
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - clear the counter (no strobe, ack seen, or not granted)
//   en        - count this cycle (granted strobe waiting for ack)
//   timeout   - one-cycle pulse, never asserted while TIMEOUT == 0
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    // Width must be at least one bit even when the watchdog is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt;

    // The pulse is qualified with en so an ack in the same cycle wins.
    assign timeout = (TIMEOUT != 0) && en && (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || timeout) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter sharing one Wishbone master port.
// The grant is registered and held for the whole cyc span, so bursts are
// atomic; a watchdog ends a stalled access with a one-cycle err pulse.
//   clk, rst            - clock, asynchronous active-low reset
//   m0_* / m1_*         - master-side Wishbone ports (adr, dat, sel, we,
//                         cyc, stb in; dat, ack, err out)
//   s_*                 - shared slave-side port (adr, dat, sel, we, cyc,
//                         stb out; dat, ack in)
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;     // index of the master served most recently
    logic       gnt_stb;
    logic       wd_en;
    logic       timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Grant FSM. Leaving a grant always passes through IDLE, which gives
    // the mandatory idle cycle between two masters' accesses.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i && (!m0_cyc_i || !last)) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_stb = ((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i);
    assign wd_en   = gnt_stb && !s_ack_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!wd_en),
        .en      (wd_en),
        .timeout (timeout)
    );

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Output mux. Ack is qualified with the master's strobe so a late ack
    // arriving after a watchdog abort (master has dropped stb) is dropped.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i && !timeout;
                m0_ack_o = s_ack_i && m0_stb_i;
                m0_err_o = timeout;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i && !timeout;
                m1_ack_o = s_ack_i && m1_stb_i;
                m1_err_o = timeout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [ADR_W-1:0]   m0_adr_i = '0, m1_adr_i = '0;
    logic [DAT_W-1:0]   m0_dat_i = '0, m1_dat_i = '0;
    logic [DAT_W-1:0]   m0_dat_o, m1_dat_o;
    logic [DAT_W/8-1:0] m0_sel_i = '0, m1_sel_i = '0;
    logic               m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic               m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic               m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic               m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [ADR_W-1:0]   s_adr_o;
    logic [DAT_W-1:0]   s_dat_o;
    logic [DAT_W/8-1:0] s_sel_o;
    logic               s_we_o, s_cyc_o, s_stb_o;
    logic [DAT_W-1:0]   s_dat_i = '0;
    logic               s_ack_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A0 = 32'h4000_0000;
    localparam logic [31:0] A1 = 32'h8000_0010;

    wb_rr_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
        .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
        .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        s_dat_i = 32'hA5A5_0001;
        m0_adr_i = A0; m1_adr_i = A1;
        m0_sel_i = 4'hF; m1_sel_i = 4'h3;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        chk("rst_s_cyc", 32'(s_cyc_o), 0);
        chk("rst_s_stb", 32'(s_stb_o), 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_m0_ack", 32'(m0_ack_o), 0);
        chk("rst_m0_dat", m0_dat_o, 32'hA5A5_0001);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 1: single m0 read, ack two cycles after s_cyc rises
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1 chk("t1_latency_cyc", 32'(s_cyc_o), 0);
        tick();
        chk("t1_s_cyc", 32'(s_cyc_o), 1);
        chk("t1_s_adr", s_adr_o, A0);
        chk("t1_s_sel", 32'(s_sel_o), 32'hF);
        chk("t1_ack_early", 32'(m0_ack_o), 0);
        tick();
        chk("t1_ack_wait", 32'(m0_ack_o), 0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("t1_m0_ack", 32'(m0_ack_o), 1);
        chk("t1_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("t1_m1_ack", 32'(m1_ack_o), 0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();

        // 2: simultaneous request right after reset -> m0 first
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("t2_first_adr", s_adr_o, A0);
        s_ack_i = 1'b1;
        #1;
        chk("t2_m0_ack", 32'(m0_ack_o), 1);
        chk("t2_m1_ack", 32'(m1_ack_o), 0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("t2_idle_gap", 32'(s_cyc_o), 0);
        tick();
        chk("t2_m1_cyc", 32'(s_cyc_o), 1);
        chk("t2_m1_adr", s_adr_o, A1);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        tick();

        // 3: 4-beat m0 burst while m1 waits (last=1 -> m0 wins)
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_burst_adr", s_adr_o, A0);
            chk("t3_m0_ack", 32'(m0_ack_o), 1);
            chk("t3_m1_ack", 32'(m1_ack_o), 0);
            tick();
        end
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("t3_idle_gap", 32'(s_cyc_o), 0);
        tick();
        chk("t3_m1_adr", s_adr_o, A1);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        tick();

        // 4: slave never acks, err pulse when 8 wait cycles are counted
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t4_no_err", 32'(m0_err_o), 0);
            chk("t4_stb_on", 32'(s_stb_o), 1);
            tick();
        end
        chk("t4_err", 32'(m0_err_o), 1);
        chk("t4_stb_forced", 32'(s_stb_o), 0);
        chk("t4_cyc_held", 32'(s_cyc_o), 1);
        chk("t4_no_ack", 32'(m0_ack_o), 0);
        tick();
        m0_stb_i = 1'b0;
        #1 chk("t4_err_pulse", 32'(m0_err_o), 0);
        s_ack_i = 1'b1;
        #1 chk("t4_late_ack", 32'(m0_ack_o), 0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0;
        tick();
        tick();

        // 5: ack in the cycle the counter reaches TIMEOUT -> ack wins
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        s_ack_i = 1'b1;
        #1;
        chk("t5_ack", 32'(m0_ack_o), 1);
        chk("t5_no_err", 32'(m0_err_o), 0);
        chk("t5_stb", 32'(s_stb_o), 1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();

        // 6: reset during an m1 burst (last=0 so m1 wins first)
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("t6_m1_gnt", s_adr_o, A1);
        s_ack_i = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_cyc", 32'(s_cyc_o), 0);
        chk("t6_rst_stb", 32'(s_stb_o), 0);
        chk("t6_rst_ack", 32'(m1_ack_o), 0);
        tick();
        s_ack_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_post_rst_m0", s_adr_o, A0);
        chk("t6_post_rst_cyc", 32'(s_cyc_o), 1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
